mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-client arbiter between the instruction cache and the data cache miss/write-back ports and the single main-memory port. Each cache presents a block request (read or write-back) on its next-level interface; the arbiter grants one at a time, forwards it to memory and returns the memory response to the owning cache. It adds one cycle of request latency and no response latency, and is transparent to the caches' valid/ready protocol.

## Interface
Parameters:
- BW_ADDRESS, 32, byte address width
- BW_BLOCK, 128, block data width

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- p0_valid  input  1  I-cache request valid (held until p0_ready)
- p0_r0w1  input  1  I-cache request type, 0 read, 1 write
- p0_rwaddr  input  BW_ADDRESS  I-cache request address
- p0_wdata  input  BW_BLOCK  I-cache write block
- p0_ready  output  1  one-cycle completion pulse to I-cache
- p0_rdata  output  BW_BLOCK  read block to I-cache, valid with p0_ready
- p1_valid / p1_r0w1 / p1_rwaddr / p1_wdata / p1_ready / p1_rdata  same as port 0, for the D-cache
- m_valid  output  1  memory request valid
- m_r0w1  output  1  memory request type
- m_rwaddr  output  BW_ADDRESS  memory request address
- m_wdata  output  BW_BLOCK  memory write block
- m_ready  input  1  memory completion pulse
- m_rdata  input  BW_BLOCK  memory read block, valid with m_ready

## Operation
- States: IDLE, BUSY. Registers: state, owner (1 bit), last_grant (1 bit), m_valid, m_r0w1, m_rwaddr, m_wdata.
- IDLE: if p0_valid or p1_valid, select winner, latch its r0w1/rwaddr/wdata into m_* registers, set m_valid=1, owner=winner, last_grant=winner, go BUSY. No request: stay IDLE, m_valid=0, m_* data registers hold.
- BUSY: m_valid and m_* held. Port requests are ignored (not re-sampled). When m_ready=1: m_valid cleared at next edge, go IDLE.
- Responses (combinational): pN_ready = (state==BUSY) && m_ready && (owner==N); pN_rdata = pN_ready ? m_rdata : 0. Non-owner ready always 0.
- Write requests complete on m_ready as well; m_rdata ignored by client.
- A client keeps its valid high in the m_ready cycle; the arbiter never re-samples in that cycle, since it is BUSY. A client presenting a new request the next cycle (write-back followed by fill) is re-arbitrated in IDLE.
- Arbitration policy: see Configuration.
- m_ready while IDLE: ignored, no pN_ready.

## Timing
- Reset: state=IDLE, m_valid=0, m_r0w1=0, m_rwaddr=0, m_wdata=0, owner=0, last_grant=1 (port 0 wins first tie); p0_ready=p1_ready=0, p0_rdata=p1_rdata=0.
- pN_valid rising at edge t (sampled in IDLE) -> m_valid=1 from edge t+1.
- m_ready at cycle c -> pN_ready in cycle c (same cycle); m_valid=0 from c+1; IDLE in c+1; next grant's m_valid earliest c+2.
- Reset asserted mid-BUSY: outputs return to reset values immediately; in-flight request is dropped; memory must also be reset.
- m_ready in the same cycle as entry to BUSY cannot occur (m_valid is low before then); memory must not pulse ready without valid.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin; when both valid in IDLE, grant the port != last_grant; a single requester always wins.
- Not defined: fixed priority, port 1 (D-cache) always wins ties; last_grant still updated but unused.

## Test plan
- Single read: p0 read addr 0x0000_1000, memory returns 0xAAAA..AA after 3 cycles -> m_valid one cycle after request, p0_ready pulse with p0_rdata=0xAAAA..AA, p1_ready stays 0.
- Simultaneous requests after reset, round-robin: p0 read 0x100, p1 write 0x200 -> p0 granted first, then p1; m_r0w1=1, m_wdata=p1_wdata on second transaction.
- Fixed priority (macro undefined): same stimulus -> p1 write 0x200 granted first, p0 second.
- Back-to-back write-back then fill from p1 (write 0x300, then read 0x400) with p0 continuously requesting, round-robin -> grant order p1 write, p0, p1 read; no grant lost.
- Stray m_ready while IDLE -> no pN_ready, state stays IDLE.
- rst_n low during BUSY -> m_valid=0 immediately; after release, pending p0 request granted with m_valid rising one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-client arbiter from the I-cache/D-cache next-level ports onto one memory port.
// `define MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise port 1 wins ties.
module mem_port_arbiter #(
    parameter int BW_ADDRESS = 32,
    parameter int BW_BLOCK   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_valid,
    input  logic                  p0_r0w1,
    input  logic [BW_ADDRESS-1:0] p0_rwaddr,
    input  logic [BW_BLOCK-1:0]   p0_wdata,
    output logic                  p0_ready,
    output logic [BW_BLOCK-1:0]   p0_rdata,
    input  logic                  p1_valid,
    input  logic                  p1_r0w1,
    input  logic [BW_ADDRESS-1:0] p1_rwaddr,
    input  logic [BW_BLOCK-1:0]   p1_wdata,
    output logic                  p1_ready,
    output logic [BW_BLOCK-1:0]   p1_rdata,
    output logic                  m_valid,
    output logic                  m_r0w1,
    output logic [BW_ADDRESS-1:0] m_rwaddr,
    output logic [BW_BLOCK-1:0]   m_wdata,
    input  logic                  m_ready,
    input  logic [BW_BLOCK-1:0]   m_rdata
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  m_valid_q;
    logic                  m_r0w1_q;
    logic [BW_ADDRESS-1:0] m_rwaddr_q;
    logic [BW_BLOCK-1:0]   m_wdata_q;

    logic                  grant_d;
    logic                  r0w1_d;
    logic [BW_ADDRESS-1:0] rwaddr_d;
    logic [BW_BLOCK-1:0]   wdata_d;

    // A lone requester always wins; a tie goes to the port not granted last (round-robin) or to port 1.
    always_comb begin
        grant_d = p1_valid;
        if (p0_valid && p1_valid)
            grant_d = RR_EN ? ~last_grant_q : 1'b1;
        r0w1_d   = grant_d ? p1_r0w1   : p0_r0w1;
        rwaddr_d = grant_d ? p1_rwaddr : p0_rwaddr;
        wdata_d  = grant_d ? p1_wdata  : p0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            m_valid_q    <= 1'b0;
            m_r0w1_q     <= 1'b0;
            m_rwaddr_q   <= '0;
            m_wdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p0_valid || p1_valid) begin
                        state_q      <= BUSY;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        m_valid_q    <= 1'b1;
                        m_r0w1_q     <= r0w1_d;
                        m_rwaddr_q   <= rwaddr_d;
                        m_wdata_q    <= wdata_d;
                    end else begin
                        m_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // Client valids are not re-sampled here; a still-high valid in the
                    // completion cycle belongs to the finished request.
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid  = m_valid_q;
    assign m_r0w1   = m_r0w1_q;
    assign m_rwaddr = m_rwaddr_q;
    assign m_wdata  = m_wdata_q;

    assign p0_ready = (state_q == BUSY) && m_ready && !owner_q;
    assign p1_ready = (state_q == BUSY) && m_ready &&  owner_q;
    assign p0_rdata = p0_ready ? m_rdata : '0;
    assign p1_rdata = p1_ready ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two client drivers, a 3-cycle memory model,
// and a monitor that checks every client completion against the expected grant order.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int BW = 128;
    localparam logic [BW-1:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [BW-1:0] W2 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          p0_valid, p0_r0w1, p0_ready, p1_valid, p1_r0w1, p1_ready;
    logic [AW-1:0] p0_rwaddr, p1_rwaddr, m_rwaddr;
    logic [BW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, m_wdata, m_rdata;
    logic          m_valid, m_r0w1, m_ready, mem_rdy, stray_rdy;
    assign m_ready = mem_rdy | stray_rdy;

    mem_port_arbiter #(.BW_ADDRESS(AW), .BW_BLOCK(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_r0w1(p0_r0w1), .p0_rwaddr(p0_rwaddr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_r0w1(p1_r0w1), .p1_rwaddr(p1_rwaddr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .m_valid(m_valid), .m_r0w1(m_r0w1), .m_rwaddr(m_rwaddr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            port;
        bit            r0w1;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk(input bit port, input bit rw, input logic [AW-1:0] a,
                                input logic [BW-1:0] wd, input logic [BW-1:0] rd);
        exp_t e;
        e.port = port; e.r0w1 = rw; e.addr = a; e.wdata = wd; e.rdata = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit v, input bit rw,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
        if (!port) begin
            p0_valid = v; p0_r0w1 = rw; p0_rwaddr = a; p0_wdata = d;
        end else begin
            p1_valid = v; p1_r0w1 = rw; p1_rwaddr = a; p1_wdata = d;
        end
    endtask

    // Called just after a rising edge; holds the request through its ready cycle.
    task automatic req(input bit port, input bit rw, input logic [AW-1:0] a, input logic [BW-1:0] d);
        bit done = 1'b0;
        drive(port, 1'b1, rw, a, d);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (port ? p1_ready : p0_ready) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL req_timeout port%0d addr %h: no ready within 60 cycles", port, a);
        end
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, '0, '0);
    endtask

    // Memory: answers 3 cycles after seeing m_valid; read block is ~addr replicated, 0x1000 gives all A.
    initial begin
        int cnt;
        cnt = 0; mem_rdy = 1'b0; m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || mem_rdy) begin
                mem_rdy = 1'b0; cnt = 0;
            end else if (m_valid) begin
                cnt++;
                if (cnt == 3) begin
                    mem_rdy = 1'b1;
                    m_rdata = (m_rwaddr == 32'h1000) ? {32{4'hA}} : {4{~m_rwaddr}};
                end
            end
        end
    end

    // Monitor: every client completion pops one expected transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (p0_ready || p1_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: p0_ready %b p1_ready %b with empty scoreboard", p0_ready, p1_ready);
                end else begin
                    e = sb.pop_front();
                    chk("both_ready", p0_ready && p1_ready, 1'b0);
                    chk("ready_port", p1_ready, e.port);
                    chk("m_valid_at_ready", m_valid, 1'b1);
                    chk("m_r0w1", m_r0w1, e.r0w1);
                    chk("m_rwaddr", m_rwaddr, e.addr);
                    chk("m_wdata", m_wdata, e.wdata);
                    chk("owner_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                    chk("other_rdata", e.port ? p0_rdata : p1_rdata, '0);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        stray_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_r0w1", m_r0w1, 1'b0);
        chk("rst_m_rwaddr", m_rwaddr, '0);
        chk("rst_m_wdata", m_wdata, '0);
        chk("rst_p0_ready", p0_ready, 1'b0);
        chk("rst_p1_ready", p1_ready, 1'b0);
        chk("rst_p0_rdata", p0_rdata, '0);
        chk("rst_p1_rdata", p1_rdata, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read with request latency check
        sb.push_back(mk(1'b0, 1'b0, 32'h1000, '0, {32{4'hA}}));
        fork
            req(1'b0, 1'b0, 32'h1000, '0);
            begin
                @(negedge clk); chk("lat_m_valid_req_cycle", m_valid, 1'b0);
                @(negedge clk); chk("lat_m_valid_next", m_valid, 1'b1);
                chk("lat_m_rwaddr", m_rwaddr, 32'h1000);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Stray m_ready while idle
        stray_rdy = 1'b1;
        @(negedge clk);
        chk("stray_p0_ready", p0_ready, 1'b0);
        chk("stray_p1_ready", p1_ready, 1'b0);
        @(posedge clk); #1;
        stray_rdy = 1'b0;
        @(negedge clk);
        chk("stray_stays_idle", m_valid, 1'b0);

        // Simultaneous requests straight after reset
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sb.push_back(mk(1'b0, 1'b0, 32'h100, '0, {4{32'hFFFF_FEFF}}));
        sb.push_back(mk(1'b1, 1'b1, 32'h200, W1, {4{32'hFFFF_FDFF}}));
`else
        sb.push_back(mk(1'b1, 1'b1, 32'h200, W1, {4{32'hFFFF_FDFF}}));
        sb.push_back(mk(1'b0, 1'b0, 32'h100, '0, {4{32'hFFFF_FEFF}}));
`endif
        fork
            req(1'b0, 1'b0, 32'h100, '0);
            req(1'b1, 1'b1, 32'h200, W1);
        join
        repeat (2) @(posedge clk);
        #1;

        // p1 write-back then fill, p0 requesting throughout
        sb.push_back(mk(1'b1, 1'b1, 32'h300, W2, {4{32'hFFFF_FCFF}}));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sb.push_back(mk(1'b0, 1'b0, 32'h500, '0, {4{32'hFFFF_FAFF}}));
        sb.push_back(mk(1'b1, 1'b0, 32'h400, '0, {4{32'hFFFF_FBFF}}));
`else
        sb.push_back(mk(1'b1, 1'b0, 32'h400, '0, {4{32'hFFFF_FBFF}}));
        sb.push_back(mk(1'b0, 1'b0, 32'h500, '0, {4{32'hFFFF_FAFF}}));
`endif
        fork
            begin
                req(1'b1, 1'b1, 32'h300, W2);
                req(1'b1, 1'b0, 32'h400, '0);
            end
            begin
                @(posedge clk); #1;
                req(1'b0, 1'b0, 32'h500, '0);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset during BUSY drops the in-flight request; the held p0 request is re-granted
        sb.push_back(mk(1'b0, 1'b0, 32'h600, '0, {4{32'hFFFF_F9FF}}));
        fork
            req(1'b0, 1'b0, 32'h600, '0);
            begin
                repeat (2) @(negedge clk);
                chk("busy_before_reset", m_valid, 1'b1);
                rst_n = 1'b0;
                #1;
                chk("midrst_m_valid", m_valid, 1'b0);
                chk("midrst_m_rwaddr", m_rwaddr, '0);
                chk("midrst_p0_ready", p0_ready, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk("release_m_valid", m_valid, 1'b0);
                @(negedge clk);
                chk("regrant_m_valid", m_valid, 1'b1);
                chk("regrant_m_rwaddr", m_rwaddr, 32'h600);
            end
        join

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
